// File: rtl/cfg_rom_axi_responder.sv
// AXI4 read-only responder for the configuration descriptor ROM.
// Reads support FIXED/INCR/WRAP bursts; every write is drained and answered SLVERR.
module cfg_rom_axi_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter logic [AxiAddrWidth-1:0] BaseAddr = 64'h0000_0000_0001_0000,
  parameter int unsigned NumWords     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumWords*64-1:0]  rom_words_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [63:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiIdWidth-1:0]   aw_id_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [AxiIdWidth-1:0]   b_id_o,
  output logic [1:0]              b_resp_o
);

  localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;

  if (AxiDataWidth != 64) begin : g_width_check
    $error("cfg_rom_axi_responder: AxiDataWidth must be 64");
  end

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_t;

  logic [63:0] rom_word [NumWords];

  for (genvar gi = 0; gi < NumWords; gi++) begin : g_rom_unpack
    assign rom_word[gi] = rom_words_i[64*gi +: 64];
  end

  r_state_t                r_state_reg;
  logic                    ar_ready_reg;
  logic [AxiIdWidth-1:0]   ar_id_reg;
  logic [AxiAddrWidth-1:0] addr_reg;
  logic [7:0]              len_reg;
  logic [7:0]              cnt_reg;
  logic [2:0]              size_reg;
  logic [1:0]              burst_reg;
  logic                    r_valid_reg;
  logic [63:0]             r_data_reg;
  logic [1:0]              r_resp_reg;
  logic                    r_last_reg;

  w_state_t                w_state_reg;
  logic                    aw_ready_reg;
  logic                    w_ready_reg;
  logic                    b_valid_reg;
  logic [1:0]              b_resp_reg;
  logic [AxiIdWidth-1:0]   aw_id_reg;

  // Address of the beat that follows the one currently presented.
  logic [AxiAddrWidth-1:0] wrap_mask;
  logic                    cur_wrap_ok;
  logic [AxiAddrWidth-1:0] next_addr;

  always_comb begin
    wrap_mask   = ((AxiAddrWidth'(len_reg) + AxiAddrWidth'(1)) << 3) - AxiAddrWidth'(1);
    cur_wrap_ok = (len_reg == 8'd1) || (len_reg == 8'd3) || (len_reg == 8'd7) || (len_reg == 8'd15);
    next_addr   = addr_reg + AxiAddrWidth'(8);
    if (burst_reg == 2'b00) begin
      next_addr = addr_reg;
    end else if (burst_reg == 2'b10 && cur_wrap_ok) begin
      next_addr = (addr_reg & ~wrap_mask) | ((addr_reg + AxiAddrWidth'(8)) & wrap_mask);
    end
  end

  // Beat lookup: from the AR channel when idle, otherwise for the next burst address.
  logic [AxiAddrWidth-1:0] lk_addr;
  logic [AxiAddrWidth-1:0] lk_offset;
  logic [7:0]              lk_len;
  logic [2:0]              lk_size;
  logic [1:0]              lk_burst;
  logic                    lk_wrap_ok;
  logic                    lk_slverr;
  logic                    lk_in_window;
  logic [IdxW-1:0]         lk_index;
  logic [63:0]             beat_data;
  logic [1:0]              beat_resp;

  always_comb begin
    lk_addr  = (r_state_reg == R_IDLE) ? ar_addr_i  : next_addr;
    lk_len   = (r_state_reg == R_IDLE) ? ar_len_i   : len_reg;
    lk_size  = (r_state_reg == R_IDLE) ? ar_size_i  : size_reg;
    lk_burst = (r_state_reg == R_IDLE) ? ar_burst_i : burst_reg;
    lk_offset    = lk_addr - BaseAddr;
    lk_index     = lk_offset[IdxW+2:3];
    lk_in_window = (lk_addr >= BaseAddr) && ((lk_offset >> 3) < AxiAddrWidth'(NumWords));
    lk_wrap_ok   = (lk_len == 8'd1) || (lk_len == 8'd3) || (lk_len == 8'd7) || (lk_len == 8'd15);
    lk_slverr    = (lk_size != 3'd3) || (lk_burst == 2'b11) || (lk_burst == 2'b10 && !lk_wrap_ok);
    beat_data    = 64'd0;
    if (lk_slverr) begin
      beat_resp = 2'b10;
    end else if (!lk_in_window) begin
      beat_resp = 2'b11;
    end else begin
      beat_resp = 2'b00;
      beat_data = rom_word[lk_index];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_reg  <= R_IDLE;
      ar_ready_reg <= 1'b1;
      ar_id_reg    <= '0;
      addr_reg     <= '0;
      len_reg      <= 8'd0;
      cnt_reg      <= 8'd0;
      size_reg     <= 3'd0;
      burst_reg    <= 2'b00;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= 64'd0;
      r_resp_reg   <= 2'b00;
      r_last_reg   <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_valid_i && ar_ready_reg) begin
            ar_id_reg    <= ar_id_i;
            addr_reg     <= ar_addr_i;
            len_reg      <= ar_len_i;
            size_reg     <= ar_size_i;
            burst_reg    <= ar_burst_i;
            cnt_reg      <= 8'd0;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b1;
            r_data_reg   <= beat_data;
            r_resp_reg   <= beat_resp;
            r_last_reg   <= (ar_len_i == 8'd0);
            r_state_reg  <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_ready_i) begin
            if (r_last_reg) begin
              r_valid_reg  <= 1'b0;
              r_data_reg   <= 64'd0;
              r_resp_reg   <= 2'b00;
              r_last_reg   <= 1'b0;
              ar_ready_reg <= 1'b1;
              r_state_reg  <= R_IDLE;
            end else begin
              cnt_reg    <= cnt_reg + 8'd1;
              addr_reg   <= next_addr;
              r_data_reg <= beat_data;
              r_resp_reg <= beat_resp;
              r_last_reg <= ((cnt_reg + 8'd1) == len_reg);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_reg  <= W_IDLE;
      aw_ready_reg <= 1'b1;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= 2'b00;
      aw_id_reg    <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_valid_i && aw_ready_reg) begin
            aw_id_reg    <= aw_id_i;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b1;
            w_state_reg  <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          if (w_valid_i && w_last_i) begin
            w_ready_reg <= 1'b0;
            b_valid_reg <= 1'b1;
            b_resp_reg  <= 2'b10;
            w_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= 2'b00;
            aw_ready_reg <= 1'b1;
            w_state_reg  <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  assign ar_ready_o = ar_ready_reg;
  assign r_valid_o  = r_valid_reg;
  assign r_id_o     = ar_id_reg;
  assign r_data_o   = r_data_reg;
  assign r_resp_o   = r_resp_reg;
  assign r_last_o   = r_last_reg;
  assign aw_ready_o = aw_ready_reg;
  assign w_ready_o  = w_ready_reg;
  assign b_valid_o  = b_valid_reg;
  assign b_id_o     = aw_id_reg;
  assign b_resp_o   = b_resp_reg;

endmodule

// File: tb/tb_cfg_rom_axi_responder.sv
// Directed bench for cfg_rom_axi_responder: read bursts, error responses,
// write draining and mid-burst reset.
module tb_cfg_rom_axi_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
  localparam int NW = 32;

  logic              clk;
  logic              rst;
  logic [NW*64-1:0]  rom_words;
  logic              ar_valid;
  logic              ar_ready;
  logic [3:0]        ar_id;
  logic [63:0]       ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              r_valid;
  logic              r_ready;
  logic [3:0]        r_id;
  logic [63:0]       r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              aw_valid;
  logic              aw_ready;
  logic [3:0]        aw_id;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic              b_valid;
  logic              b_ready;
  logic [3:0]        b_id;
  logic [1:0]        b_resp;

  int n_assert = 0;
  int n_fail   = 0;

  cfg_rom_axi_responder dut (
    .clk_i(clk), .rst_i(rst), .rom_words_i(rom_words),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] rom_w(input int k);
    if (k == 2) return 64'hDEAD_BEEF_0000_0040;
    return {32'hC0F1_0000 | 32'(k), 32'h5A00_0000 | 32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_valid = 1'b1;
    ar_id    = id;
    ar_addr  = addr;
    ar_len   = len;
    ar_size  = size;
    ar_burst = burst;
    check("ar_ready_idle", 64'(ar_ready), 64'd1);
    tick();
    ar_valid = 1'b0;
  endtask

  // Checks one presented beat, holding r_ready low for 'stall' cycles first.
  task automatic beat(input string tag, input logic [63:0] d, input logic [1:0] resp,
                      input logic last, input logic [3:0] id, input int stall);
    for (int s = 0; s <= stall; s++) begin
      check({tag, "_valid"}, 64'(r_valid), 64'd1);
      check({tag, "_data"}, r_data, d);
      check({tag, "_resp"}, 64'(r_resp), 64'(resp));
      check({tag, "_last"}, 64'(r_last), 64'(last));
      check({tag, "_id"}, 64'(r_id), 64'(id));
      check({tag, "_arready"}, 64'(ar_ready), 64'd0);
      r_ready = (s == stall);
      tick();
    end
    r_ready = 1'b0;
    $display("beat %s data=%h resp=%0d last=%0d", tag, r_data, r_resp, r_last);
  endtask

  task automatic check_rd_idle(input string tag);
    check({tag, "_idle_arready"}, 64'(ar_ready), 64'd1);
    check({tag, "_idle_rvalid"}, 64'(r_valid), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < NW; k++) rom_words[k*64 +: 64] = rom_w(k);
    rst = 1'b1;
    ar_valid = 1'b0; ar_id = 4'd0; ar_addr = 64'd0; ar_len = 8'd0; ar_size = 3'd0; ar_burst = 2'b00;
    r_ready = 1'b0; aw_valid = 1'b0; aw_id = 4'd0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_ar_ready", 64'(ar_ready), 64'd1);
    check("rst_aw_ready", 64'(aw_ready), 64'd1);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_r_data", r_data, 64'd0);
    check("rst_r_resp", 64'(r_resp), 64'd0);
    check("rst_r_last", 64'(r_last), 64'd0);
    check("rst_r_id", 64'(r_id), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_b_resp", 64'(b_resp), 64'd0);
    check("rst_b_id", 64'(b_id), 64'd0);
    rst = 1'b0;
    tick();

    // Single beat from word 2
    send_ar(4'd5, BASE + 64'd16, 8'd0, 3'd3, 2'b01);
    beat("single", 64'hDEAD_BEEF_0000_0040, 2'b00, 1'b1, 4'd5, 0);
    check_rd_idle("single");

    // INCR len=3 with stalls on beats 2 and 4
    send_ar(4'd2, BASE + 64'd8, 8'd3, 3'd3, 2'b01);
    beat("incr_b1", rom_w(1), 2'b00, 1'b0, 4'd2, 0);
    beat("incr_b2", rom_w(2), 2'b00, 1'b0, 4'd2, 1);
    beat("incr_b3", rom_w(3), 2'b00, 1'b0, 4'd2, 0);
    beat("incr_b4", rom_w(4), 2'b00, 1'b1, 4'd2, 1);
    check_rd_idle("incr");

    // WRAP len=3 from +0x10: words 2,3,0,1
    send_ar(4'd7, BASE + 64'h10, 8'd3, 3'd3, 2'b10);
    beat("wrap_b1", rom_w(2), 2'b00, 1'b0, 4'd7, 0);
    beat("wrap_b2", rom_w(3), 2'b00, 1'b0, 4'd7, 0);
    beat("wrap_b3", rom_w(0), 2'b00, 1'b0, 4'd7, 0);
    beat("wrap_b4", rom_w(1), 2'b00, 1'b1, 4'd7, 0);

    // WRAP with illegal len=2: three SLVERR beats
    send_ar(4'd7, BASE + 64'h10, 8'd2, 3'd3, 2'b10);
    beat("wrapbad_b1", 64'd0, 2'b10, 1'b0, 4'd7, 0);
    beat("wrapbad_b2", 64'd0, 2'b10, 1'b0, 4'd7, 0);
    beat("wrapbad_b3", 64'd0, 2'b10, 1'b1, 4'd7, 0);

    // INCR crossing the window end
    send_ar(4'd1, BASE + 64'hF0, 8'd3, 3'd3, 2'b01);
    beat("edge_b1", rom_w(30), 2'b00, 1'b0, 4'd1, 0);
    beat("edge_b2", rom_w(31), 2'b00, 1'b0, 4'd1, 0);
    beat("edge_b3", 64'd0, 2'b11, 1'b0, 4'd1, 0);
    beat("edge_b4", 64'd0, 2'b11, 1'b1, 4'd1, 0);

    // Unsupported size
    send_ar(4'd1, BASE, 8'd3, 3'd2, 2'b01);
    beat("size_b1", 64'd0, 2'b10, 1'b0, 4'd1, 0);
    beat("size_b2", 64'd0, 2'b10, 1'b0, 4'd1, 0);
    beat("size_b3", 64'd0, 2'b10, 1'b0, 4'd1, 0);
    beat("size_b4", 64'd0, 2'b10, 1'b1, 4'd1, 0);

    // Reserved burst type, address below window, FIXED burst
    send_ar(4'd4, BASE, 8'd0, 3'd3, 2'b11);
    beat("rsvd", 64'd0, 2'b10, 1'b1, 4'd4, 0);
    send_ar(4'd4, BASE - 64'd8, 8'd0, 3'd3, 2'b01);
    beat("below", 64'd0, 2'b11, 1'b1, 4'd4, 0);
    send_ar(4'd6, BASE + 64'd24, 8'd1, 3'd3, 2'b00);
    beat("fixed_b1", rom_w(3), 2'b00, 1'b0, 4'd6, 0);
    beat("fixed_b2", rom_w(3), 2'b00, 1'b1, 4'd6, 0);

    // W beat before AW must not be accepted
    w_valid = 1'b1; w_last = 1'b1;
    check("w_before_aw_ready", 64'(w_ready), 64'd0);
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    check("w_before_aw_bvalid", 64'(b_valid), 64'd0);

    // Write with a concurrent two-beat read
    aw_valid = 1'b1; aw_id = 4'd9;
    check("aw_ready_idle", 64'(aw_ready), 64'd1);
    send_ar(4'd3, BASE, 8'd1, 3'd3, 2'b01);
    aw_valid = 1'b0;
    check("wr_aw_ready_busy", 64'(aw_ready), 64'd0);
    check("wr_w_ready_1", 64'(w_ready), 64'd1);
    w_valid = 1'b1; w_last = 1'b0;
    beat("conc_b1", rom_w(0), 2'b00, 1'b0, 4'd3, 0);
    check("wr_w_ready_2", 64'(w_ready), 64'd1);
    check("wr_b_valid_early", 64'(b_valid), 64'd0);
    beat("conc_b2", rom_w(1), 2'b00, 1'b1, 4'd3, 0);
    check_rd_idle("conc");
    w_last = 1'b1;
    check("wr_w_ready_3", 64'(w_ready), 64'd1);
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wr_b_valid", 64'(b_valid), 64'd1);
      check("wr_b_resp", 64'(b_resp), 64'd2);
      check("wr_b_id", 64'(b_id), 64'd9);
      check("wr_w_ready_resp", 64'(w_ready), 64'd0);
      b_ready = (c == 2);
      tick();
    end
    b_ready = 1'b0;
    $display("write id=9 answered resp=2");
    check("wr_b_valid_done", 64'(b_valid), 64'd0);
    check("wr_aw_ready_done", 64'(aw_ready), 64'd1);

    // Reset during the second beat of a len=7 read
    send_ar(4'd8, BASE, 8'd7, 3'd3, 2'b01);
    beat("abort_b1", rom_w(0), 2'b00, 1'b0, 4'd8, 0);
    check("abort_b2_data", r_data, rom_w(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_r_valid", 64'(r_valid), 64'd0);
    check("abort_ar_ready", 64'(ar_ready), 64'd1);
    tick();
    check("abort_r_valid_after", 64'(r_valid), 64'd0);
    send_ar(4'd10, BASE + 64'd40, 8'd0, 3'd3, 2'b01);
    beat("after_rst", rom_w(5), 2'b00, 1'b1, 4'd10, 0);
    check_rd_idle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_rom_axi_responder.md
Name: cfg_rom_axi_responder

Overview:
- AXI4 subordinate that serves a read-only configuration descriptor ROM (XLEN, cache geometry, TLB depths, PMP count, extension bits) to software and debug.
- It is the responder end of the core's AXI4 initiator port.
- Sits on the peripheral crossbar. ROM words arrive packed on an input bus built from the core's configuration constants.
- Reads are burst-capable. All writes are accepted, drained and answered SLVERR.

Parameters:
- AxiIdWidth, 4, width of AR/R/AW/B ID fields
- AxiAddrWidth, 64, address width
- AxiDataWidth, 64, data width; fixed at 64, elaboration error otherwise
- BaseAddr, 64'h0000_0000_0001_0000, byte base of the ROM window
- NumWords, 32, number of 64-bit ROM words; window size is NumWords*8 bytes

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rom_words_i  in  NumWords*64  packed ROM contents; word k is bits [64k+63:64k]
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  AxiIdWidth  read ID
- ar_addr_i  in  AxiAddrWidth  read byte address
- ar_len_i  in  8  beats minus one
- ar_size_i  in  3  log2 bytes per beat
- ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  AxiIdWidth  read ID echo
- r_data_o  out  64  read data
- r_resp_o  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- r_last_o  out  1  last beat
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  AxiIdWidth  write ID
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  AxiIdWidth  write ID echo
- b_resp_o  out  2  write response, always 10

Behaviour:
- Reset: all outputs 0 except ar_ready_o=1 and aw_ready_o=1. Both FSMs go to IDLE.
- Reset asserted mid-burst aborts the burst. No further R/B beats are issued for it.

Read FSM, states R_IDLE and R_BURST:
- R_IDLE: ar_ready_o=1. On ar_valid_i & ar_ready_o, latch id, addr, len, size, burst and a beat counter = 0, then go to R_BURST.
- First r_valid_o appears in the cycle after the AR handshake (1-cycle latency).
- R_BURST: ar_ready_o=0. r_valid_o is held with stable id/data/resp/last until r_ready_i.
- On each R handshake the counter increments and the address advances. The next beat is valid in the same following cycle, with no bubble.
- On the handshake with r_last_o=1, go to R_IDLE; ar_ready_o=1 in the next cycle.
- r_last_o = (counter == len).

Read address and response rules:
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr += 8.
  - WRAP: wrap boundary = (len+1)*8, and addr = (addr & ~(boundary-1)) | ((addr+8) & (boundary-1)).
  - WRAP with len not in {1,3,7,15} returns SLVERR on every beat.
- Burst value 11: SLVERR on every beat.
- ar_size_i != 3: SLVERR on every beat, data 0. len+1 beats are still returned.
- Word index = (addr - BaseAddr) >> 3, with the low 3 address bits ignored.
- addr < BaseAddr or index >= NumWords: that beat only returns DECERR with data 0. An INCR burst crossing the window end turns DECERR mid-burst.
- OKAY beat: r_data_o = rom word at the index, registered.

Write FSM, states W_IDLE, W_DRAIN, W_RESP:
- W_IDLE: aw_ready_o=1. On AW handshake, latch id and go to W_DRAIN.
- W_DRAIN: w_ready_o=1 and all beats are discarded. On the w_last_i handshake go to W_RESP.
- W_RESP: b_valid_o=1, b_resp_o=10, b_id_o = latched id. Held until b_ready_i, then W_IDLE.
- W beats arriving before AW are not accepted (w_ready_o=0 outside W_DRAIN).

Concurrency:
- Read and write FSMs are independent; simultaneous AR and AW handshakes are both accepted in the same cycle.
- Only one outstanding read and one outstanding write at a time.

Test Plan:
- rom_words_i word2=64'hDEAD_BEEF_0000_0040. AR addr=BaseAddr+16, len=0, size=3, INCR, id=5 -> one beat the next cycle: data 64'hDEAD_BEEF_0000_0040, resp 00, id 5, last=1.
- INCR len=3 from BaseAddr+8, r_ready toggling 1,0,1,0 -> words 1..4 in order. Data stays stable during stalls. last only on beat 4. ar_ready=0 until the cycle after the final handshake.
- WRAP len=3 from BaseAddr+0x10 -> words 2,3,0,1. WRAP len=2 -> 3 beats, all SLVERR.
- INCR len=3 from BaseAddr+0xF0 (NumWords=32) -> words 30,31 OKAY, then 2 beats DECERR with data 0. size=2 -> 4 beats SLVERR.
- AW id=9, then 3 W beats with w_last on the third, b_ready delayed 2 cycles -> b_valid held until ready, b_resp 10, b_id 9. A concurrent read completes unaffected.
- rst_i asserted in the 2nd beat of a len=7 read -> next cycle r_valid=0 and ar_ready=1. A new read returns correct data.
